// File: rtl/cvi_stream_rx.sv
// cvi_stream_rx: clocked-video receiver.
// Samples a clocked video bus, frames every active picture into an Avalon-ST video data
// packet (header word 32'h0 with SOP, pixels, EOP on the last pixel), buffers the packet
// in a show-ahead FIFO and measures the active width/height of each frame.
//
// Optional feature (macro CVI_RX_CTRL_PKT_EN): when defined, every data packet is preceded
// by a two-word control packet: 32'hF (SOP), then {meas_height, meas_width} (EOP).
//
// Ports:
//   clk_clk            sole clock (video and fabric)
//   reset_reset        synchronous, active-high reset
//   vid_data           pixel word
//   vid_datavalid      pixel qualifier; falling edge ends a line
//   vid_h_sync         horizontal sync, informational only
//   vid_v_sync         vertical sync, rising edge marks a frame boundary
//   dout_*             Avalon-ST source, ready latency 0
//   overflow           sticky FIFO-overflow flag, cleared by overflow_clr pulse
//   meas_width         pixels in the last line of the last frame
//   meas_height        lines with at least one pixel in the last frame
module cvi_stream_rx #(
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [31:0] vid_data,
   input  logic        vid_datavalid,
   input  logic        vid_h_sync,
   input  logic        vid_v_sync,
   output logic [31:0] dout_data,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        dout_startofpacket,
   output logic        dout_endofpacket,
   output logic        overflow,
   input  logic        overflow_clr,
   output logic [15:0] meas_width,
   output logic [15:0] meas_height
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
`ifdef CVI_RX_CTRL_PKT_EN
   localparam int unsigned START_WORDS = 3;
`else
   localparam int unsigned START_WORDS = 1;
`endif

   typedef enum logic [2:0] {StIdle, StWait, StActive, StFlush, StDrop} state_e;

   state_e        state_q;
   logic [31:0]   stage_q;
   logic          stage_vld_q;
   logic          vsync_q, dv_q;
   logic          vs_rise, pix_acc, line_end;

   // FIFO words are {eop, sop, data}
   logic [33:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, free;
   logic [33:0]   head;
   logic          pop;
   logic [1:0]    push_n;
   logic [33:0]   push_word [3];
   logic          ovf_set;

   logic [15:0]   pix_cnt_q, line_cnt_q, last_width_q;
   logic [15:0]   width_now, lines_now;

   logic          unused_h_sync;
   assign unused_h_sync = vid_h_sync;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'h1;
   endfunction

   assign vs_rise  = vid_v_sync & ~vsync_q;
   assign pix_acc  = vid_datavalid & ~vid_v_sync;
   assign line_end = dv_q & ~vid_datavalid;

   assign head               = mem_q[rd_ptr_q];
   assign dout_valid         = (count_q != '0);
   assign dout_data          = dout_valid ? head[31:0] : 32'h0;
   assign dout_startofpacket = dout_valid & head[32];
   assign dout_endofpacket   = dout_valid & head[33];
   assign pop                = dout_valid & dout_ready;
   // A slot freed by this cycle's pop may be refilled in the same cycle.
   assign free = (AW+1)'(FIFO_DEPTH) - count_q + {{AW{1'b0}}, pop};

   // A line still open at the frame boundary counts as the last line.
   assign width_now = (pix_cnt_q != 16'h0) ? pix_cnt_q : last_width_q;
   assign lines_now = (pix_cnt_q != 16'h0) ? sat_inc(line_cnt_q) : line_cnt_q;

   // Push decision for this cycle; pixel acceptance excludes a v_sync rise.
   always_comb begin
      push_n       = 2'd0;
      push_word[0] = '0;
      push_word[1] = '0;
      push_word[2] = '0;
      ovf_set      = 1'b0;
      case (state_q)
         StWait: begin
            if (pix_acc) begin
               if (free >= (AW+1)'(START_WORDS)) begin
`ifdef CVI_RX_CTRL_PKT_EN
                  push_word[0] = {2'b01, 32'hF};
                  push_word[1] = {2'b10, meas_height, meas_width};
                  push_word[2] = {2'b01, 32'h0};
                  push_n       = 2'd3;
`else
                  push_word[0] = {2'b01, 32'h0};
                  push_n       = 2'd1;
`endif
               end else begin
                  ovf_set = 1'b1;
               end
            end
         end
         StActive: begin
            if (pix_acc) begin
               if (free != '0) begin
                  push_word[0] = {2'b00, stage_q};
                  push_n       = 2'd1;
               end else begin
                  ovf_set = 1'b1;
               end
            end
         end
         StFlush: begin
            if (free != '0) begin
               push_word[0] = {2'b10, stage_q};
               push_n       = 2'd1;
            end
         end
         default: ;
      endcase
   end

   // Show-ahead FIFO, up to three writes per cycle.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (i < int'(push_n)) mem_q[wr_ptr_q + AW'(i)] <= push_word[i];
         end
         wr_ptr_q <= wr_ptr_q + AW'(push_n);
         rd_ptr_q <= rd_ptr_q + AW'(pop);
         count_q  <= count_q + (AW+1)'(push_n) - (AW+1)'(pop);
      end
   end

   // Framing FSM.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q     <= StIdle;
         stage_q     <= 32'h0;
         stage_vld_q <= 1'b0;
         vsync_q     <= 1'b0;
         dv_q        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         vsync_q <= vid_v_sync;
         dv_q    <= vid_datavalid;
         if (ovf_set) overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
         case (state_q)
            StIdle:   if (vs_rise) state_q <= StWait;
            StWait: begin
               if (ovf_set) begin
                  state_q <= StDrop;
               end else if (push_n != 2'd0) begin
                  state_q     <= StActive;
                  stage_q     <= vid_data;
                  stage_vld_q <= 1'b1;
               end
            end
            StActive: begin
               if (vs_rise) state_q <= StFlush;
               else if (ovf_set) state_q <= StDrop;
               else if (push_n != 2'd0) stage_q <= vid_data;
            end
            StFlush: begin
               if (push_n != 2'd0) begin
                  state_q     <= StWait;
                  stage_vld_q <= 1'b0;
               end
            end
            // A packet already opened must still be closed with EOP.
            StDrop:   if (vs_rise) state_q <= stage_vld_q ? StFlush : StWait;
            default:  state_q <= StIdle;
         endcase
      end
   end

   // Width/height measurement, running once synchronised to a frame boundary.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         pix_cnt_q    <= 16'h0;
         line_cnt_q   <= 16'h0;
         last_width_q <= 16'h0;
         meas_width   <= 16'h0;
         meas_height  <= 16'h0;
      end else if (state_q != StIdle) begin
         if (vs_rise) begin
            if (lines_now != 16'h0) begin
               meas_width  <= width_now;
               meas_height <= lines_now;
            end
            pix_cnt_q    <= 16'h0;
            line_cnt_q   <= 16'h0;
            last_width_q <= 16'h0;
         end else if (pix_acc) begin
            pix_cnt_q <= sat_inc(pix_cnt_q);
         end else if (line_end && pix_cnt_q != 16'h0) begin
            last_width_q <= pix_cnt_q;
            line_cnt_q   <= sat_inc(line_cnt_q);
            pix_cnt_q    <= 16'h0;
         end
      end
   end

endmodule

// File: tb/tb_cvi_stream_rx.sv
module tb_cvi_stream_rx;

   localparam int DEPTH = 8;
`ifdef CVI_RX_CTRL_PKT_EN
   localparam int START = 3;
   localparam bit CTRL  = 1'b1;
`else
   localparam int START = 1;
   localparam bit CTRL  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_reset, vid_datavalid, vid_h_sync, vid_v_sync;
   logic [31:0] vid_data;
   logic [31:0] dout_data;
   logic        dout_valid, dout_ready, dout_startofpacket, dout_endofpacket;
   logic        overflow, overflow_clr;
   logic [15:0] meas_width, meas_height;

   always #5 clk = ~clk;

   cvi_stream_rx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_clk            (clk),
      .reset_reset        (reset_reset),
      .vid_data           (vid_data),
      .vid_datavalid      (vid_datavalid),
      .vid_h_sync         (vid_h_sync),
      .vid_v_sync         (vid_v_sync),
      .dout_data          (dout_data),
      .dout_valid         (dout_valid),
      .dout_ready         (dout_ready),
      .dout_startofpacket (dout_startofpacket),
      .dout_endofpacket   (dout_endofpacket),
      .overflow           (overflow),
      .overflow_clr       (overflow_clr),
      .meas_width         (meas_width),
      .meas_height        (meas_height)
   );

   typedef struct packed {logic sop; logic eop; logic [31:0] data;} beat_t;

   int checks = 0, errors = 0;
   int cyc_n = 0, rdy_mode = 0, pix = 1;
   beat_t got[$], exp_beats[$];
   logic [34:0] prev_out;
   bit prev_stall;

   // Reference model: the expected FIFO contents as a queue, framing as booleans.
   beat_t mq[$];
   bit m_synced, m_has, m_drop, m_flush, m_prev_vs, m_prev_dv, m_ovf;
   logic [31:0] m_held;
   logic [15:0] m_w, m_h;
   int m_lines[$];
   int m_cur;

   function automatic beat_t mk(input logic sop, input logic eop, input logic [31:0] d);
      beat_t b;
      b.sop = sop; b.eop = eop; b.data = d;
      return b;
   endfunction

   function automatic void model_reset();
      mq.delete(); m_lines.delete();
      m_synced = 0; m_has = 0; m_drop = 0; m_flush = 0; m_prev_vs = 0; m_prev_dv = 0;
      m_ovf = 0; m_held = '0; m_w = '0; m_h = '0; m_cur = 0;
   endfunction

   function automatic void model_step(input bit dv, input logic [31:0] d, input bit vs,
                                      input bit rdy, input bit clr);
      bit rise, acc, ovf_ev, was_synced;
      int free;
      rise = vs && !m_prev_vs;
      acc = dv && !vs;
      ovf_ev = 0;
      was_synced = m_synced;
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      free = DEPTH - mq.size();
      if (!m_synced) begin
         if (rise) m_synced = 1;
      end else if (m_flush) begin
         if (free > 0) begin
            mq.push_back(mk(1'b0, 1'b1, m_held));
            m_flush = 0; m_has = 0;
         end
      end else if (m_drop) begin
         if (rise) begin m_drop = 0; m_flush = m_has; end
      end else if (m_has) begin
         if (rise) m_flush = 1;
         else if (acc) begin
            if (free > 0) begin mq.push_back(mk(1'b0, 1'b0, m_held)); m_held = d; end
            else begin ovf_ev = 1; m_drop = 1; end
         end
      end else if (acc) begin
         if (free >= START) begin
            if (CTRL) begin
               mq.push_back(mk(1'b1, 1'b0, 32'hF));
               mq.push_back(mk(1'b0, 1'b1, {m_h, m_w}));
            end
            mq.push_back(mk(1'b1, 1'b0, 32'h0));
            m_held = d; m_has = 1;
         end else begin
            ovf_ev = 1; m_drop = 1;
         end
      end
      if (was_synced) begin
         if (rise) begin
            if (m_cur > 0) m_lines.push_back(m_cur);
            if (m_lines.size() > 0) begin
               m_w = 16'(m_lines[$]);
               m_h = 16'(m_lines.size());
            end
            m_lines.delete(); m_cur = 0;
         end else if (acc) m_cur++;
         else if (m_prev_dv && !dv && m_cur > 0) begin
            m_lines.push_back(m_cur); m_cur = 0;
         end
      end
      if (ovf_ev) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_prev_vs = vs; m_prev_dv = dv;
   endfunction

   function automatic logic [67:0] model_vec();
      beat_t b;
      b = (mq.size() != 0) ? mq[0] : beat_t'(34'h0);
      return {(mq.size() != 0), b.sop, b.eop, b.data, m_ovf, m_w, m_h};
   endfunction

   function automatic logic [67:0] dut_vec();
      return {dout_valid, dout_startofpacket, dout_endofpacket, dout_data, overflow,
              meas_width, meas_height};
   endfunction

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, exp);
      end
   endtask

   // One clock: drive inputs after the falling edge, compare, advance model.
   task automatic cyc(input bit dv, input logic [31:0] d, input bit vs,
                      input bit clr = 1'b0, input bit rst = 1'b0);
      bit rdy;
      case (rdy_mode)
         0:       rdy = 1'b1;
         1:       rdy = cyc_n[0];
         2:       rdy = 1'b0;
         default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      vid_datavalid = dv; vid_data = d; vid_v_sync = vs; vid_h_sync = ~dv;
      dout_ready = rdy; overflow_clr = clr; reset_reset = rst;
      #1;
      check("outputs", dut_vec(), model_vec());
      if (prev_stall)
         check("stall_hold", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data},
               prev_out);
      prev_stall = dout_valid && !dout_ready && !rst;
      prev_out = {dout_valid, dout_startofpacket, dout_endofpacket, dout_data};
      if (dout_valid && dout_ready)
         got.push_back(mk(dout_startofpacket, dout_endofpacket, dout_data));
      if (rst) model_reset();
      else model_step(dv, d, vs, rdy, clr);
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 32'h0, 1'b0);
   endtask

   task automatic vpulse();
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0);
   endtask

   task automatic line(input int w);
      for (int i = 0; i < w; i++) begin
         cyc(1'b1, 32'(pix), 1'b0);
         pix++;
      end
      idle(2);
   endtask

   function automatic void expect_frame(input int last, input logic [15:0] pw,
                                        input logic [15:0] ph);
      exp_beats.delete();
      if (CTRL) begin
         exp_beats.push_back(mk(1'b1, 1'b0, 32'hF));
         exp_beats.push_back(mk(1'b0, 1'b1, {ph, pw}));
      end
      exp_beats.push_back(mk(1'b1, 1'b0, 32'h0));
      for (int k = 1; k <= last; k++) exp_beats.push_back(mk(1'b0, k == last, 32'(k)));
   endfunction

   task automatic compare_beats(input string name);
      check({name, "_count"}, 68'(got.size()), 68'(exp_beats.size()));
      for (int i = 0; i < got.size() && i < exp_beats.size(); i++)
         check(name, 68'(got[i]), 68'(exp_beats[i]));
   endtask

   typedef struct {int w; int h; int mode; logic [15:0] exp_w; logic [15:0] exp_h;} vec_t;
   vec_t vecs[3];
   logic [15:0] pw, ph;

   initial begin
      vecs[0] = '{w: 4, h: 2, mode: 0, exp_w: 16'd4, exp_h: 16'd2};
      vecs[1] = '{w: 4, h: 2, mode: 1, exp_w: 16'd4, exp_h: 16'd2};
      vecs[2] = '{w: 3, h: 5, mode: 0, exp_w: 16'd3, exp_h: 16'd5};

      reset_reset = 1'b1; vid_datavalid = 1'b0; vid_data = '0; vid_v_sync = 1'b0;
      vid_h_sync = 1'b0; dout_ready = 1'b1; overflow_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      prev_stall = 0;
      check("reset_state", dut_vec(), 68'h0);

      // Table-driven frames; each packet is closed by the following v_sync rise.
      vpulse();
      pw = '0; ph = '0;
      foreach (vecs[v]) begin
         rdy_mode = vecs[v].mode;
         got.delete();
         pix = 1;
         for (int l = 0; l < vecs[v].h; l++) line(vecs[v].w);
         vpulse();
         rdy_mode = 0;
         idle(14);
         expect_frame(vecs[v].w * vecs[v].h, pw, ph);
         compare_beats("frame_beats");
         check("meas_width", 68'(meas_width), 68'(vecs[v].exp_w));
         check("meas_height", 68'(meas_height), 68'(vecs[v].exp_h));
         pw = vecs[v].exp_w; ph = vecs[v].exp_h;
      end

      // Overflow with a stalled sink, then release and clear.
      rdy_mode = 2;
      got.delete();
      pix = 1;
      line(DEPTH + 4);
      check("overflow_set", 68'(overflow), 68'h1);
      vpulse();
      rdy_mode = 0;
      idle(DEPTH + 6);
      expect_frame(DEPTH - START + 1, pw, ph);
      compare_beats("ovf_beats");
      check("overflow_sticky", 68'(overflow), 68'h1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      check("overflow_clr", 68'(overflow), 68'h0);
      check("ovf_meas", {36'h0, meas_width, meas_height}, {36'h0, 16'(DEPTH + 4), 16'd1});
      pw = 16'(DEPTH + 4); ph = 16'd1;

      // Frame boundaries without pixels.
      got.delete();
      vpulse(); idle(3); vpulse(); idle(3);
      check("no_packet", 68'(got.size()), 68'h0);
      check("meas_unchanged", {36'h0, meas_width, meas_height}, {36'h0, pw, ph});

      // Reset in the middle of a frame, then a complete frame after resync.
      cyc(1'b1, 32'd1, 1'b0); cyc(1'b1, 32'd2, 1'b0); cyc(1'b1, 32'd3, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("reset_clears", dut_vec(), 68'h0);
      vpulse();
      got.delete();
      pix = 1;
      line(4); line(4);
      vpulse();
      idle(14);
      expect_frame(8, 16'd0, 16'd0);
      compare_beats("post_reset_beats");
      check("post_reset_meas", {36'h0, meas_width, meas_height}, {36'h0, 16'd4, 16'd2});

      // Randomised traffic against the model.
      rdy_mode = 3;
      for (int f = 0; f < 60; f++) begin
         int nl;
         nl = $urandom_range(0, 4);
         for (int l = 0; l < nl; l++) begin
            int w;
            w = $urandom_range(0, 6);
            for (int i = 0; i < w; i++) cyc(1'b1, $urandom, 1'b0);
            repeat ($urandom_range(1, 3))
               cyc(1'b0, 32'h0, 1'b0, ($urandom_range(0, 15) == 0));
         end
         repeat ($urandom_range(1, 3)) cyc(1'($urandom_range(0, 1)), $urandom, 1'b1);
         cyc(1'b0, 32'h0, 1'b0);
         if ($urandom_range(0, 19) == 0) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      end
      rdy_mode = 0;
      idle(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cvi_stream_rx.md
# cvi_stream_rx

Clocked-video receiver: the input-side counterpart of the video timing output path. Samples a clocked video bus (data, datavalid, h/v sync), frames each active picture into an Avalon-ST video data packet (type header + pixels, SOP/EOP), buffers it in a show-ahead FIFO, and measures active width/height. Sits between a camera/decoder pin interface and the frame-buffer writer in the FPGA fabric. The video clock and the fabric clock are the same clock.

## Interface
- FIFO_DEPTH, 16: output FIFO words; power of 2, >= 4.
- clk_clk  in  1  sole clock; video bus sampled on rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- vid_data  in  32  pixel word.
- vid_datavalid  in  1  pixel qualifier.
- vid_h_sync  in  1  horizontal sync; informational only.
- vid_v_sync  in  1  vertical sync, active high.
- dout_data  out  32  stream data.
- dout_valid  out  1  stream valid.
- dout_ready  in  1  stream ready; ready latency 0.
- dout_startofpacket  out  1  first beat of packet.
- dout_endofpacket  out  1  last beat of packet.
- overflow  out  1  sticky FIFO-overflow flag.
- overflow_clr  in  1  one-cycle pulse, clears overflow.
- meas_width  out  16  pixels in last line of last frame.
- meas_height  out  16  lines holding >= 1 pixel in last frame.

## Operation
- Reset: all outputs 0; FIFO emptied; stage register empty; state IDLE.
- Pixel accepted only when vid_datavalid=1 and vid_v_sync=0. Frame boundary = vid_v_sync rising edge (registered previous value). Line end = vid_datavalid falling edge.
- IDLE: ignore everything; on v_sync rise -> WAIT.
- WAIT: on first accepted pixel: push header word 32'h0 with SOP into FIFO, load pixel into stage register -> ACTIVE. FIFO full at that point -> set overflow, -> DROP (no header written).
- ACTIVE: each accepted pixel pushes stage contents (no flags) into FIFO and reloads stage. On v_sync rise -> FLUSH.
- FLUSH: push stage with EOP when FIFO not full; then -> WAIT. Pixels arriving while in FLUSH are discarded.
- Overflow in ACTIVE (push needed, FIFO full): set overflow, discard the incoming pixel, keep stage, -> DROP. DROP discards pixels; on v_sync rise -> FLUSH (packet always terminated with EOP; DROP entered from WAIT goes directly to WAIT).
- v_sync rise with no pixel since the last frame boundary: no packet emitted.
- Measurement: pixel counter per line, line counter per frame (16-bit, saturating at 16'hFFFF). On v_sync rise, meas_width <= last completed line pixel count, meas_height <= line count, counters clear; frames with zero lines leave measurements unchanged.
- overflow set has priority over overflow_clr in the same cycle.
- FIFO pop when dout_valid & dout_ready. Push and pop in same cycle when full allowed only if pop occurs (full counts after pop).

## Timing
- Header: in FIFO at cycle N+1 after first pixel sampled at N; dout_valid rises at N+1 if FIFO was empty.
- Pixel k is pushed when pixel k+1 is sampled; last pixel pushed in FLUSH, >= 1 cycle after v_sync rise.
- FIFO show-ahead: dout_data/flags valid in same cycle as dout_valid; held stable while dout_valid=1 and dout_ready=0.
- meas_* update one cycle after v_sync rise sampled.
- Reset mid-frame: packet abandoned without EOP, FIFO flushed, resync at next v_sync rise.

## Configuration
- CVI_RX_CTRL_PKT_EN defined: at WAIT exit, before the data header, push control packet: word 32'hF (SOP), then {meas_height, meas_width} (EOP); requires 3 free FIFO slots, else frame dropped and overflow set.
- Undefined: only data packets emitted; no control words.

## Test plan
- 4x2 frame, pixels 1..8, dout_ready=1 -> beats 0(SOP),1..7,8(EOP); meas_width=4, meas_height=2.
- Same frame, dout_ready toggling 1/0 each cycle -> identical beat sequence, data stable while stalled.
- FIFO_DEPTH=4, dout_ready=0, 8-pixel line -> overflow=1 after 5th push attempt; after ready=1, packet ends with EOP on last staged pixel; overflow_clr pulse -> overflow=0.
- Two v_sync pulses with no datavalid -> no dout_valid; meas_* unchanged.
- With CVI_RX_CTRL_PKT_EN, second 4x2 frame -> beats F(SOP), 0x00020004(EOP), then data packet.
- reset_reset asserted after 3 pixels -> all outputs 0 next cycle; next frame after v_sync rise emitted complete.
